// File: rtl/sram_responder.sv
// Board-side SRAM stand-in for the SLC-3 memory bus: answers OE/WE strobes with
// programmable read/write wait states and offers a side port for program preload.
module sram_responder #(
    parameter int ADDR_W  = 10,
    parameter int RD_WAIT = 1,
    parameter int WR_WAIT = 1
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic [15:0]       ADDR,
    input  logic              OE,
    input  logic              WE,
    input  logic [15:0]       Data_to_SRAM,
    output logic [15:0]       Data_from_SRAM,
    output logic              Ready,
    output logic              Range_Err,
    output logic              Bus_Err,
    input  logic              Load_En,
    input  logic [ADDR_W-1:0] Load_Addr,
    input  logic [15:0]       Load_Data
);

    localparam logic [3:0] RD_CNT = 4'(RD_WAIT);
    localparam logic [3:0] WR_CNT = 4'(WR_WAIT);

    typedef enum logic [1:0] {S_IDLE, S_RD_WAIT, S_WR_WAIT, S_HOLD} state_t;

    state_t      r_state;
    state_t      w_next_state;
    logic [3:0]  r_cnt;
    logic [3:0]  w_cnt_next;
    logic [15:0] r_addr;
    logic [15:0] r_wdata;
    logic [15:0] r_rdata;
    logic        r_ready;
    logic        r_range_err;
    logic        r_bus_err;
    logic [15:0] r_mem [2**ADDR_W];

    logic        w_accept;
    logic        w_load;
    logic        w_rd_done;
    logic        w_wr_done;
    logic        w_conflict;
    logic        w_oor;

    // Upper address bits beyond the implemented array flag an out-of-range access.
    assign w_oor = |r_addr[15:ADDR_W];

    always_comb begin
        w_next_state = r_state;
        w_cnt_next   = r_cnt;
        w_accept     = 1'b0;
        w_load       = 1'b0;
        w_rd_done    = 1'b0;
        w_wr_done    = 1'b0;
        w_conflict   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (Load_En) begin
                    w_load = 1'b1;
                end else if (!WE) begin
                    w_next_state = S_WR_WAIT;
                    w_cnt_next   = WR_CNT;
                    w_accept     = 1'b1;
                    w_conflict   = !OE;
                end else if (!OE) begin
                    w_next_state = S_RD_WAIT;
                    w_cnt_next   = RD_CNT;
                    w_accept     = 1'b1;
                end
            end
            S_RD_WAIT: begin
                if (r_cnt != 4'd0) begin
                    w_cnt_next = r_cnt - 4'd1;
                end else begin
                    w_rd_done    = 1'b1;
                    w_next_state = S_HOLD;
                end
            end
            S_WR_WAIT: begin
                if (r_cnt != 4'd0) begin
                    w_cnt_next = r_cnt - 4'd1;
                end else begin
                    w_wr_done    = 1'b1;
                    w_next_state = S_HOLD;
                end
            end
            S_HOLD: begin
                // One access per strobe assertion: wait for both strobes to go idle.
                if (OE && WE) begin
                    w_next_state = S_IDLE;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_cnt_next;
        end
    end

    always_ff @(posedge Clk) begin
        if (w_accept) begin
            r_addr  <= ADDR;
            r_wdata <= Data_to_SRAM;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_rdata     <= 16'h0000;
            r_ready     <= 1'b0;
            r_range_err <= 1'b0;
            r_bus_err   <= 1'b0;
        end else begin
            r_ready     <= w_rd_done | w_wr_done;
            r_range_err <= (w_rd_done | w_wr_done) & w_oor;
            if (w_rd_done) begin
                r_rdata <= w_oor ? 16'h0000 : r_mem[r_addr[ADDR_W-1:0]];
            end
            if (w_conflict) begin
                r_bus_err <= 1'b1;
            end
        end
    end

    // Array contents survive Reset; a Reset edge suppresses any write at that edge.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            if (w_load) begin
                r_mem[Load_Addr] <= Load_Data;
            end else if (w_wr_done && !w_oor) begin
                r_mem[r_addr[ADDR_W-1:0]] <= r_wdata;
            end
        end
    end

    assign Data_from_SRAM = r_rdata;
    assign Ready          = r_ready;
    assign Range_Err      = r_range_err;
    assign Bus_Err        = r_bus_err;

endmodule

// File: tb/tb_sram_responder.sv
// Directed bench for sram_responder: expected read data comes from a bench-side
// memory model via a scoreboard queue, checked when Ready pulses.
module tb_sram_responder;

    localparam int ADDR_W = 10;
    localparam int RD_W   = 1;
    localparam int WR_W   = 2;

    logic              Clk = 1'b0;
    logic              Reset = 1'b1;
    logic [15:0]       ADDR = 16'h0000;
    logic              OE = 1'b1;
    logic              WE = 1'b1;
    logic [15:0]       Data_to_SRAM = 16'h0000;
    logic [15:0]       Data_from_SRAM;
    logic              Ready;
    logic              Range_Err;
    logic              Bus_Err;
    logic              Load_En = 1'b0;
    logic [ADDR_W-1:0] Load_Addr = '0;
    logic [15:0]       Load_Data = 16'h0000;

    logic [15:0] model [2**ADDR_W];
    logic [15:0] sb_q [$];
    logic [15:0] last_rd;
    int          n_vec = 0;
    int          n_err = 0;

    sram_responder #(
        .ADDR_W (ADDR_W),
        .RD_WAIT(RD_W),
        .WR_WAIT(WR_W)
    ) dut (
        .Clk           (Clk),
        .Reset         (Reset),
        .ADDR          (ADDR),
        .OE            (OE),
        .WE            (WE),
        .Data_to_SRAM  (Data_to_SRAM),
        .Data_from_SRAM(Data_from_SRAM),
        .Ready         (Ready),
        .Range_Err     (Range_Err),
        .Bus_Err       (Bus_Err),
        .Load_En       (Load_En),
        .Load_Addr     (Load_Addr),
        .Load_Data     (Load_Data)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic load(input int a, input logic [15:0] d);
        Load_En   = 1'b1;
        Load_Addr = ADDR_W'(a);
        Load_Data = d;
        model[a]  = d;
        @(negedge Clk);
        Load_En = 1'b0;
    endtask

    task automatic wait_ready(output int lat);
        lat = 99;
        for (int n = 1; n <= 20; n++) begin
            @(negedge Clk);
            if (Ready === 1'b1) begin
                lat = n;
                break;
            end
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_data"}, Data_from_SRAM, 16'h0000);
        check({tag, "_ready"}, Ready, 1'b0);
        check({tag, "_rerr"}, Range_Err, 1'b0);
        check({tag, "_berr"}, Bus_Err, 1'b0);
    endtask

    task automatic do_read(input string tag, input logic [15:0] a, input int exp_lat);
        logic [15:0] exp;
        logic        oor;
        int          lat;
        oor = (a[15:ADDR_W] != '0);
        OE   = 1'b0;
        ADDR = a;
        sb_q.push_back(oor ? 16'h0000 : model[a[ADDR_W-1:0]]);
        wait_ready(lat);
        check({tag, "_lat"}, lat, exp_lat);
        exp = sb_q.pop_front();
        check({tag, "_data"}, Data_from_SRAM, exp);
        check({tag, "_rerr"}, Range_Err, oor);
        last_rd = exp;
        @(negedge Clk);
        check({tag, "_pulse"}, Ready, 1'b0);
        check({tag, "_rpulse"}, Range_Err, 1'b0);
        check({tag, "_hold"}, Data_from_SRAM, exp);
        OE = 1'b1;
        @(negedge Clk);
    endtask

    task automatic do_write(input string tag, input logic [15:0] a, input logic [15:0] d,
                            input logic both_low);
        logic oor;
        int   lat;
        oor = (a[15:ADDR_W] != '0);
        WE           = 1'b0;
        OE           = both_low ? 1'b0 : 1'b1;
        ADDR         = a;
        Data_to_SRAM = d;
        if (!oor) model[a[ADDR_W-1:0]] = d;
        @(negedge Clk);
        // Bus changes after acceptance must not reach the array.
        Data_to_SRAM = 16'h0000;
        ADDR         = 16'h0001;
        wait_ready(lat);
        check({tag, "_lat"}, lat + 1, WR_W + 2);
        check({tag, "_rdhold"}, Data_from_SRAM, last_rd);
        check({tag, "_rerr"}, Range_Err, oor);
        @(negedge Clk);
        check({tag, "_pulse"}, Ready, 1'b0);
        WE = 1'b1;
        OE = 1'b1;
        @(negedge Clk);
    endtask

    initial begin
        int lat;
        last_rd = 16'h0000;
        repeat (2) @(negedge Clk);
        Reset = 1'b0;
        check_reset_outputs("rst");

        // Preload and first read with RD_WAIT latency
        load(5, 16'h1234);
        do_read("rd5", 16'h0005, RD_W + 2);

        // Write with mid-wait bus changes, then read back
        do_write("wr7", 16'h0007, 16'hBEEF, 1'b0);
        check("berr_clean", Bus_Err, 1'b0);
        do_read("rd7", 16'h0007, RD_W + 2);

        // Simultaneous strobes: write wins, Bus_Err sticks
        do_write("both3", 16'h0003, 16'h00AA, 1'b1);
        check("berr_set", Bus_Err, 1'b1);
        do_read("rd3", 16'h0003, RD_W + 2);
        check("berr_sticky", Bus_Err, 1'b1);

        // Out-of-range accesses
        load(0, 16'h0F0F);
        do_read("oor_rd", 16'h8000, RD_W + 2);
        do_write("oor_wr", 16'h8000, 16'hDEAD, 1'b0);
        do_read("rd0", 16'h0000, RD_W + 2);

        // Reset during WR_WAIT abandons the write
        load(9, 16'h1111);
        WE           = 1'b0;
        ADDR         = 16'h0009;
        Data_to_SRAM = 16'h2222;
        @(negedge Clk);
        Reset = 1'b1;
        WE    = 1'b1;
        @(negedge Clk);
        Reset = 1'b0;
        check_reset_outputs("midrst");
        last_rd = 16'h0000;
        repeat (4) @(negedge Clk);
        check("midrst_idle_rdy", Ready, 1'b0);
        do_read("rd9", 16'h0009, RD_W + 2);

        // Load_En and OE together in IDLE: load first, read accepted next cycle
        Load_En   = 1'b1;
        Load_Addr = ADDR_W'(12);
        Load_Data = 16'h5A5A;
        model[12] = 16'h5A5A;
        OE        = 1'b0;
        ADDR      = 16'h000C;
        sb_q.push_back(16'h5A5A);
        @(negedge Clk);
        Load_En = 1'b0;
        wait_ready(lat);
        check("ldrd_lat", lat + 1, RD_W + 3);
        check("ldrd_data", Data_from_SRAM, sb_q.pop_front());
        OE = 1'b1;
        @(negedge Clk);
        @(negedge Clk);

        // Load_En during RD_WAIT is ignored
        OE   = 1'b0;
        ADDR = 16'h000C;
        sb_q.push_back(model[12]);
        @(negedge Clk);
        Load_En   = 1'b1;
        Load_Addr = ADDR_W'(12);
        Load_Data = 16'hFFFF;
        @(negedge Clk);
        Load_En = 1'b0;
        wait_ready(lat);
        check("ldign_lat", lat + 2, RD_W + 2);
        check("ldign_data", Data_from_SRAM, sb_q.pop_front());
        OE = 1'b1;
        @(negedge Clk);
        @(negedge Clk);
        do_read("ldign_chk", 16'h000C, RD_W + 2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout required completion");
        $fatal(1, "watchdog");
    end

endmodule
